udma_jtag_dr_engine: RTL
========================

UDMA_JTAG_DR_ENGINE -- requirements
Module: udma_jtag_dr_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width; DR length is DATA_WIDTH+2 (34 by default).
REQ-002 SHALL have one clock, jtag_tck_i, input, 1, TCK; every register is clocked on its rising edge.
REQ-003 SHALL have reset jtag_trstn_i, input, 1, asynchronous and active-low.
REQ-004 SHALL have jtag_tdi_i, input, 1, serial data in.
REQ-005 SHALL have jtag_tdo_o, output, 1, serial data out.
REQ-006 SHALL have jtag_capture_dr_i, jtag_shift_dr_i, jtag_pause_dr_i and jtag_update_dr_i, each input, 1, TAP DR-state qualifiers, at most one high per cycle.
REQ-007 SHALL have data_tx_i (input, DATA_WIDTH), data_tx_valid_i (input, 1) and data_tx_ready_o (output, 1): the device-to-host word from the upstream dual-clock FIFO.
REQ-008 SHALL have data_rx_o (output, DATA_WIDTH), data_rx_valid_o (output, 1) and data_rx_ready_i (input, 1): the host-to-device word to the downstream dual-clock FIFO.

Function
REQ-009 SHALL hold a DR shift register sr[DATA_WIDTH+1:0] and a shift counter cnt that saturates at DATA_WIDTH+2.
REQ-010 SHALL implement FSM states IDLE, CAPTURED, SHIFTING and PAUSED.
REQ-011 SHALL make these FSM transitions:
  - capture: any state -> CAPTURED.
  - shift: CAPTURED/SHIFTING/PAUSED -> SHIFTING.
  - pause: SHIFTING -> PAUSED.
  - update: any state -> IDLE.
REQ-012 SHALL, on capture, load sr = {rx_space, data_tx_valid_i, data_tx_i}, where rx_space = !data_rx_valid_o; set tx_cap = data_tx_valid_i; clear cnt.
REQ-013 SHALL, on each shift cycle, load sr = {jtag_tdi_i, sr[DATA_WIDTH+1:1]} and increment cnt (saturating); LSB goes first.
REQ-014 SHALL drive jtag_tdo_o = sr[0] combinationally.
REQ-015 SHALL hold sr and cnt unchanged in PAUSED, IDLE, and in CAPTURED without shift.
REQ-016 SHALL define the update word as valid only if cnt == DATA_WIDTH+2; otherwise update causes no side effects apart from returning to IDLE.
REQ-017 SHALL, on a valid update with sr[DATA_WIDTH+1] = 1 (host ack) and tx_cap = 1, pulse data_tx_ready_o high for exactly that cycle; at no other time is data_tx_ready_o high.
REQ-018 SHALL, on a valid update with sr[DATA_WIDTH] = 1 (host write), load data_rx_o = sr[DATA_WIDTH-1:0] and set data_rx_valid_o on the next edge, if !data_rx_valid_o || data_rx_ready_i; otherwise drop the word.
REQ-019 SHALL hold data_rx_o and data_rx_valid_o stable until data_rx_ready_i is sampled high; the cycle after acceptance data_rx_valid_o = 0 unless a new push coincides (REQ-018).
REQ-020 SHALL treat data_tx_i as stable while data_tx_valid_i is high and data_tx_ready_o is low; the block does not register the tx word beyond sr.
REQ-021 SHALL clear tx_cap on update and on capture with data_tx_valid_i = 0.
REQ-022 SHALL, if capture occurs twice without update, re-capture and never pop.

Reset
REQ-023 SHALL, on jtag_trstn_i low, immediately set: state = IDLE, sr = 0, cnt = 0, tx_cap = 0, jtag_tdo_o = 0, data_tx_ready_o = 0, data_rx_valid_o = 0, data_rx_o = 0.
REQ-024 SHALL, on reset mid-shift or mid-pause, discard the partial word with no FIFO push or pop.

Structure
REQ-025 SHALL place the FSM state enum, DR-length localparam and DR bit indices (ACK_BIT, WR_BIT) in shared package udma_jtag_fifo_pkg.
REQ-026 SHALL be a single module with no sub-module.

Verification
REQ-027 SHALL cover tx read: data_tx_valid_i = 1 with data_tx_i = 0xDEADBEEF, then capture, 34 shifts with bit33 = 1, update -> TDO stream carries 0xDEADBEEF LSB-first, then bit32 = 1 and bit33 = 1, and data_tx_ready_o pulses one cycle.
REQ-028 SHALL cover rx write: shift in data = 0x12345678 with bit32 = 1 and bit33 = 0, then update, with data_rx_ready_i = 0 -> data_rx_o = 0x12345678 and valid held; ready = 1 -> valid drops the next cycle; no tx pop.
REQ-029 SHALL cover short shift: capture, 20 shifts, update -> no push, no pop, state IDLE.
REQ-030 SHALL cover pause: capture, 10 shifts, 5 pause cycles, 24 shifts, update -> result identical to 34 contiguous shifts.
REQ-031 SHALL cover rx full: data_rx_valid_o = 1 and ready = 0 -> captured bit33 = 0; a second write is dropped; with ready = 1 on the update cycle the new word is accepted.
REQ-032 SHALL cover reset at shift 17 -> all outputs 0, no handshake, and a subsequent full transaction succeeds.

Source files
------------

// File: rtl/udma_jtag_fifo_pkg.sv
// Shared definitions for the uDMA JTAG data-register engine: FSM states,
// DR length and the positions of the two control bits at the top of the DR.
package udma_jtag_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // DR layout for the default payload width: {ack, write, payload}
    localparam int DR_LEN  = DEFAULT_DATA_WIDTH + 2;
    localparam int ACK_BIT = DR_LEN - 1;
    localparam int WR_BIT  = DR_LEN - 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURED = 2'd1,
        ST_SHIFTING = 2'd2,
        ST_PAUSED   = 2'd3
    } dr_state_e;

    // Width-generic forms of the layout constants above
    function automatic int dr_len(input int data_width);
        return data_width + 2;
    endfunction

    function automatic int ack_bit(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int wr_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/udma_jtag_dr_engine_if.sv
// FIFO-side handshake bundle of the DR engine: the device-to-host word
// coming from the upstream FIFO and the host-to-device word going to the
// downstream FIFO.
interface udma_jtag_dr_engine_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] data_tx;
    logic                  data_tx_valid;
    logic                  data_tx_ready;
    logic [DATA_WIDTH-1:0] data_rx;
    logic                  data_rx_valid;
    logic                  data_rx_ready;

    // FIFO side: offers tx words, consumes rx words
    modport master (
        output data_tx,
        output data_tx_valid,
        input  data_tx_ready,
        input  data_rx,
        input  data_rx_valid,
        output data_rx_ready
    );

    // Engine side: pops tx words, pushes rx words
    modport slave (
        input  data_tx,
        input  data_tx_valid,
        output data_tx_ready,
        output data_rx,
        output data_rx_valid,
        input  data_rx_ready
    );

endinterface

// File: rtl/udma_jtag_dr_engine.sv
// JTAG data-register engine for the uDMA debug FIFO bridge.
// Capture loads {rx_space, tx_valid, tx_word} into the DR, the host shifts
// DATA_WIDTH+2 bits LSB-first, and a complete update acknowledges the tx word
// (bit ACK) and/or delivers a host write word (bit WR) to the rx side.
// Partial shifts are ignored on update, so an aborted scan never touches
// either FIFO.
module udma_jtag_dr_engine
    import udma_jtag_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  jtag_tck_i,
    input  logic                  jtag_trstn_i,
    input  logic                  jtag_tdi_i,
    output logic                  jtag_tdo_o,
    input  logic                  jtag_capture_dr_i,
    input  logic                  jtag_shift_dr_i,
    input  logic                  jtag_pause_dr_i,
    input  logic                  jtag_update_dr_i,
    input  logic [DATA_WIDTH-1:0] data_tx_i,
    input  logic                  data_tx_valid_i,
    output logic                  data_tx_ready_o,
    output logic [DATA_WIDTH-1:0] data_rx_o,
    output logic                  data_rx_valid_o,
    input  logic                  data_rx_ready_i
);

    localparam int DR_W   = dr_len(DATA_WIDTH);
    localparam int ACK_I  = ack_bit(DATA_WIDTH);
    localparam int WR_I   = wr_bit(DATA_WIDTH);
    localparam int CNT_W  = $clog2(DR_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dr_state_e             state_q, state_d;
    logic [DR_W-1:0]       sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tx_cap_q, tx_cap_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_ready;
    logic                  word_complete;

    assign word_complete = (cnt_q == CNT_FULL);

    // Next-state logic: one TAP qualifier at a time drives the DR and FSM
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        tx_cap_d   = tx_cap_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_ready   = 1'b0;

        // Downstream FIFO takes the pending rx word
        if (rx_valid_q && data_rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        if (jtag_capture_dr_i) begin
            // rx_space tells the host whether a write would be accepted
            sr_d     = {!rx_valid_q, data_tx_valid_i, data_tx_i};
            tx_cap_d = data_tx_valid_i;
            cnt_d    = '0;
            state_d  = ST_CAPTURED;
        end else if (jtag_shift_dr_i) begin
            // Shifting is only meaningful after a capture
            if (state_q != ST_IDLE) begin
                sr_d    = {jtag_tdi_i, sr_q[DR_W-1:1]};
                state_d = ST_SHIFTING;
                if (!word_complete) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end else if (jtag_pause_dr_i) begin
            if (state_q == ST_SHIFTING) begin
                state_d = ST_PAUSED;
            end
        end else if (jtag_update_dr_i) begin
            state_d  = ST_IDLE;
            tx_cap_d = 1'b0;
            if (word_complete) begin
                // Pop only a tx word that was actually captured
                tx_ready = sr_q[ACK_I] && tx_cap_q;
                // A write into an occupied, non-draining rx slot is dropped
                if (sr_q[WR_I] && (!rx_valid_q || data_rx_ready_i)) begin
                    rx_data_d  = sr_q[DATA_WIDTH-1:0];
                    rx_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers, cleared asynchronously by TRST
    always_ff @(posedge jtag_tck_i or negedge jtag_trstn_i) begin
        if (!jtag_trstn_i) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            tx_cap_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            tx_cap_q   <= tx_cap_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign jtag_tdo_o      = sr_q[0];
    assign data_tx_ready_o = tx_ready;
    assign data_rx_o       = rx_data_q;
    assign data_rx_valid_o = rx_valid_q;

endmodule
